// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the hard-wired zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the ID
// instruction actually reads. Writes to x0 never create a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_memread,
    output logic       o_stall
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_uses_rs1 && (i_ex_rd == i_id_rs1);
    assign w_rs2_hit = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
    assign o_stall   = i_ex_memread && (i_ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, MEM-stage
// branch redirect and load-use bubbles, with perf counters and a wait timeout.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pc_sel,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             exmem_write,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    state_e           r_state;
    logic [TO_W-1:0]  r_wait;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_timeout_err;

    logic             w_hazard;
    logic             w_freeze;
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [TO_W-1:0]  w_wait_nxt;
    logic             w_to_hit;

    load_use_detect u_lu (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_rd       (ex_rd),
        .i_ex_memread  (ex_memread),
        .o_stall       (w_hazard)
    );

    // An access that is acked in the same cycle it is requested never freezes.
    assign w_freeze   = mem_req && !mem_ack;
    assign w_wait_nxt = r_wait + TO_W'(1);
    assign w_to_hit   = (TIMEOUT != 0) && (w_wait_nxt == TO_W'(TIMEOUT));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        exmem_write = 1'b1;
        pc_sel      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (r_state == HALT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (w_freeze) begin
            // Hold everything up to EX/MEM; WB sees bubbles until the ack.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
            w_stall_evt = 1'b1;
        end else if (mem_branch_taken) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            w_flush_evt = 1'b1;
        end else if (w_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            w_stall_evt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_wait        <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_stall_evt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_evt) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state <= MEM_WAIT;
                        r_wait  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (w_freeze) begin
                        r_wait <= w_wait_nxt;
                        if (w_to_hit) begin
                            r_state       <= HALT;
                            r_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= RUN;
            endcase
        end
    end

    assign timeout_err  = r_timeout_err;
    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;
    assign state        = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=4): expected controls and
// status are queued when each step is driven and checked at the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    // {pc_write, ifid_write, pc_sel, ifid_flush, idex_flush, exmem_flush, memwb_flush, exmem_write}
    localparam logic [7:0] C_RST  = 8'b0001_1110;
    localparam logic [7:0] C_NORM = 8'b1100_0001;
    localparam logic [7:0] C_FRZ  = 8'b0000_0010;
    localparam logic [7:0] C_BR   = 8'b1111_1101;
    localparam logic [7:0] C_LU   = 8'b0000_1001;
    localparam logic [7:0] C_HLT  = 8'b0000_0000;

    typedef struct {
        logic [7:0]       ctrl;
        logic [1:0]       st;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_memread, mem_branch_taken, mem_req, mem_ack;
    logic pc_write, ifid_write, pc_sel, ifid_flush, idex_flush, exmem_flush, memwb_flush, exmem_write;
    logic timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [CNT_W-1:0] e_stall = '0;
    logic [CNT_W-1:0] e_flush = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4), .TO_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .ifid_write(ifid_write), .pc_sel(pc_sel),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .exmem_write(exmem_write), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .state(state)
    );

    // One cycle: drive inputs after the edge, queue the expectation, check at negedge.
    // Counter expectations come from the expected control class of earlier cycles.
    task automatic step(input string tag, input logic rst, input logic mreq, input logic mack,
                        input logic br, input logic mrd, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [7:0] ec, input logic [1:0] es, input logic ee);
        exp_t e, g;
        logic [7:0] obs;
        @(posedge clk);
        #1;
        reset = rst; mem_req = mreq; mem_ack = mack; mem_branch_taken = br;
        ex_memread = mrd; ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        e.ctrl = ec; e.st = es; e.stall = e_stall; e.flush = e_flush; e.err = ee;
        sb.push_back(e);
        if (rst) begin
            e_stall = '0; e_flush = '0;
        end else begin
            if (ec == C_FRZ || ec == C_LU) e_stall = e_stall + 1;
            if (ec == C_BR) e_flush = e_flush + 1;
        end
        @(negedge clk);
        checks++;
        assert (sb.size() != 0) else begin
            errors++; $error("FAIL %s.queue: got empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            g = sb.pop_front();
            obs = {pc_write, ifid_write, pc_sel, ifid_flush, idex_flush, exmem_flush, memwb_flush, exmem_write};
            checks++;
            assert (obs === g.ctrl) else begin
                errors++; $error("FAIL %s.ctrl: got %b expected %b", tag, obs, g.ctrl);
            end
            checks++;
            assert (state === g.st) else begin
                errors++; $error("FAIL %s.state: got %0d expected %0d", tag, state, g.st);
            end
            checks++;
            assert (stall_cycles === g.stall) else begin
                errors++; $error("FAIL %s.stall_cycles: got %0d expected %0d", tag, stall_cycles, g.stall);
            end
            checks++;
            assert (flush_count === g.flush) else begin
                errors++; $error("FAIL %s.flush_count: got %0d expected %0d", tag, flush_count, g.flush);
            end
            checks++;
            assert (timeout_err === g.err) else begin
                errors++; $error("FAIL %s.timeout_err: got %b expected %b", tag, timeout_err, g.err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; mem_req = 0; mem_ack = 0; mem_branch_taken = 0; ex_memread = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        @(posedge clk);
        //   tag          rst req ack br  mrd rd    rs1  u1  rs2  u2   ctrl    st  err
        step("rst",       1,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_RST,  0,  0);
        step("idle0",     0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        step("lu_rs2",    0,  0,  0,  0,  1,  5'd5, 5'd1, 1, 5'd5, 1,  C_LU,   0,  0);
        step("lu_bubble", 0,  0,  0,  0,  0,  5'd5, 5'd1, 1, 5'd5, 1,  C_NORM, 0,  0);
        step("lu_x0",     0,  0,  0,  0,  1,  5'd0, 5'd0, 1, 5'd0, 1,  C_NORM, 0,  0);
        step("lu_unused", 0,  0,  0,  0,  1,  5'd7, 5'd7, 0, 5'd3, 1,  C_NORM, 0,  0);
        step("lu_rs1",    0,  0,  0,  0,  1,  5'd7, 5'd7, 1, 5'd3, 0,  C_LU,   0,  0);
        step("idle1",     0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        step("branch",    0,  0,  0,  1,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_BR,   0,  0);
        step("idle2",     0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        step("br_lu",     0,  0,  0,  1,  1,  5'd5, 5'd0, 0, 5'd5, 1,  C_BR,   0,  0);
        step("idle3",     0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        // three frozen cycles, the ack cycle advances
        step("mw_f1",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  0,  0);
        step("mw_f2",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("mw_f3",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("mw_ack",    0,  1,  1,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 1,  0);
        step("mw_run",    0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        step("same_ack",  0,  1,  1,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        step("same_run",  0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        // branch coincident with an access: freeze first, branch on the ack cycle
        step("mb_frz",    0,  1,  0,  1,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  0,  0);
        step("mb_ack",    0,  1,  1,  1,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_BR,   1,  0);
        step("mb_run",    0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        // load-use evaluated normally on the ack cycle
        step("ml_frz",    0,  1,  0,  0,  1,  5'd9, 5'd9, 1, 5'd0, 0,  C_FRZ,  0,  0);
        step("ml_ack",    0,  1,  1,  0,  1,  5'd9, 5'd9, 1, 5'd0, 0,  C_LU,   1,  0);
        step("ml_run",    0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        // ack in the 4th un-acked MEM_WAIT cycle beats the timeout
        step("tb_f0",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  0,  0);
        step("tb_w1",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("tb_w2",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("tb_w3",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("tb_ack4",   0,  1,  1,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 1,  0);
        step("tb_run",    0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        // 4 un-acked MEM_WAIT cycles -> HALT
        step("to_f0",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  0,  0);
        step("to_w1",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("to_w2",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("to_w3",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("to_w4",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("halt",      0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_HLT,  2,  1);
        step("halt_ign",  0,  1,  1,  1,  1,  5'd5, 5'd5, 1, 5'd5, 1,  C_HLT,  2,  1);
        step("halt_rst",  1,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_RST,  2,  1);
        step("post_rst",  0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        // reset asserted while waiting on memory
        step("rw_f0",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  0,  0);
        step("rw_w1",     0,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_FRZ,  1,  0);
        step("rw_rst",    1,  1,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_RST,  1,  0);
        step("rw_run",    0,  0,  0,  0,  0,  5'd0, 5'd0, 0, 5'd0, 0,  C_NORM, 0,  0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards in ID, applies taken-branch redirects resolved in MEM, and freezes the pipeline while a data-memory access waits for acknowledge. It drives the write/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps performance counters and a memory-timeout error flag.

## Interface
Parameters:
- CNT_W, 32, width of performance counters
- TIMEOUT, 64, max MEM_WAIT cycles before error; 0 disables timeout
- TO_W, 16, width of wait counter; TIMEOUT < 2**TO_W

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of instruction in EX (ID/EX output)
- ex_memread  in  1  EX instruction is a load
- mem_branch_taken  in  1  branch in MEM resolved taken (Branch & zero)
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ack  in  1  data memory completes access this cycle
- pc_write, ifid_write  out  1  enable PC / IF/ID update
- pc_sel  out  1  1 = PC loads branch target
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  insert bubble
- exmem_write  out  1  enable EX/MEM update
- timeout_err  out  1  sticky memory-timeout error
- stall_cycles, flush_count  out  CNT_W  performance counters
- state  out  2  current FSM state

## Operation
- States: RUN=0, MEM_WAIT=1, HALT=2.
- Control outputs are combinational from state and inputs. Default (no event): all writes 1, flushes 0, pc_sel 0.
- Priority in RUN: mem freeze > branch redirect > load-use > normal.
- Mem freeze: mem_req & !mem_ack (in RUN or MEM_WAIT) → pc_write=ifid_write=exmem_write=0, idex_flush=0, memwb_flush=1; branch/load-use ignored. RUN → MEM_WAIT.
- Access completes: mem_req & mem_ack in the same cycle → no stall. In MEM_WAIT, mem_ack → pipeline advances this cycle with normal branch/load-use evaluation; next state RUN.
- Branch redirect: mem_branch_taken → pc_sel=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1; flush_count +1.
- Load-use: ex_memread & ex_rd≠0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)) → pc_write=ifid_write=0, idex_flush=1. Exactly one bubble: the flushed ID/EX clears ex_memread.
- stall_cycles +1 per cycle with a mem freeze or load-use stall. Counters wrap at 2**CNT_W.
- Wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack. If it reaches TIMEOUT (TIMEOUT≠0) → HALT.
- HALT: timeout_err=1, all writes 0, all flushes 0. Inputs ignored and counters frozen until reset.

## Timing
- While reset=1: pc_write=ifid_write=exmem_write=0, all flushes 1, pc_sel=0.
- After the reset edge: state=RUN, timeout_err=0, counters=0, wait counter=0.
- Reset asserted mid-MEM_WAIT or in HALT → RUN next edge.
- Control latency: 0 cycles (same-cycle combinational). State, counters and timeout_err update on the next posedge.
- Load-use penalty: 1 cycle. Branch penalty: 3 flushed instructions.
- MEM_WAIT of N cycles freezes the pipeline for N cycles. The ack cycle itself advances.
- Timeout boundary: with TIMEOUT=T, HALT is entered on the edge ending the T-th consecutive un-acked MEM_WAIT cycle. An ack in cycle T wins.
- mem_branch_taken & mem_req together (illegal, one instruction) → freeze wins; the branch is applied on the ack cycle.

## Structure
- pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, HALT) and the x0 register constant.
- Sub-module load_use_detect: combinational hazard compare, producing a single stall bit.
- The top block holds the FSM, wait counter and perf counters.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle with pc_write=0, idex_flush=1; stall_cycles=1; no hazard when ex_rd=0.
- Branch: mem_branch_taken=1 pulse → pc_sel=1, ifid/idex/exmem_flush=1 for one cycle; flush_count=1. Branch coincident with load-use → branch outputs only.
- Mem wait: mem_req=1, ack after 3 cycles → 3 cycles frozen with memwb_flush=1, state=1; advance on the ack cycle; stall_cycles=3; RUN after.
- Same-cycle ack: mem_req=mem_ack=1 → no stall, state stays RUN.
- Timeout: TIMEOUT=4, no ack → state=HALT after 4 wait cycles, timeout_err=1, all writes 0. Reset → RUN, counters 0.
- Reset mid-MEM_WAIT → all outputs at reset values, state=RUN next cycle.
